n101_subsys_clic_irq_cond: RTL and testbench

Parametrised interrupt conditioner and allocator between subsystem peripheral interrupt sources and the CLIC input vector.
- Per source: synchroniser, configurable trigger mode (level-high, level-low, rising edge, falling edge), enable, and an edge-pending latch cleared by CLIC acknowledge.
- Maps source i onto CLIC line IRQ_BASE+i; unmapped lines are tied to 0.
- Replaces fixed, tie-off-based interrupt allocation in the subsystem.

---
 rtl/n101_subsys_clic_irq_cond_pkg.sv | 30 +++
 rtl/n101_subsys_irq_cond_ch.sv | 62 ++++++
 rtl/n101_subsys_clic_irq_cond.sv | 79 +++++++
 tb/tb_n101_subsys_clic_irq_cond.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/n101_subsys_clic_irq_cond_pkg.sv
// Shared encodings for the CLIC interrupt conditioner: trigger modes and
// config/status field positions.
`ifndef N101_CLIC_IRQ_NUM
`define N101_CLIC_IRQ_NUM 64
`endif
`ifndef N101_CLOG2
`define N101_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package n101_subsys_clic_irq_cond_pkg;

   typedef enum logic [1:0] {
      LVL_HI    = 2'b00,
      LVL_LO    = 2'b01,
      EDGE_RISE = 2'b10,
      EDGE_FALL = 2'b11
   } irq_mode_e;

   localparam int CFG_W        = 3;
   localparam int CFG_EN_BIT   = 2;
   localparam int CFG_MODE_MSB = 1;
   localparam int CFG_MODE_LSB = 0;

   localparam int RD_W         = 5;

   function automatic logic is_edge(input irq_mode_e mode);
      return mode[1];
   endfunction

endpackage

// File: rtl/n101_subsys_irq_cond_ch.sv
// One interrupt source: synchroniser, trigger detection, pending/overrun
// tracking and its own enable/mode registers.
module n101_subsys_irq_cond_ch
   import n101_subsys_clic_irq_cond_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_EN      = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             src,
   input  logic             cfg_we,
   input  logic [CFG_W-1:0] cfg_data,
   input  logic             ack,
   output logic             irq,
   output logic             en,
   output irq_mode_e        mode,
   output logic             pending,
   output logic             overrun
);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   s;
   logic                   prev_p1;
   logic                   edge_mode;
   logic                   edge_hit;

   assign s         = sync_p0[SYNC_STAGES-1];
   assign edge_mode = is_edge(mode);
   assign edge_hit  = (mode == EDGE_FALL) ? (~s & prev_p1) : (s & ~prev_p1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= '0;
         prev_p1 <= 1'b0;
         irq     <= 1'b0;
         pending <= 1'b0;
         overrun <= 1'b0;
         en      <= RST_EN;
         mode    <= LVL_HI;
      end else begin
         sync_p0 <= SYNC_STAGES'({sync_p0, src});
         // prev follows s unconditionally so enabling never fabricates an edge
         prev_p1 <= s;
         irq     <= edge_mode ? pending : (en & (s ^ mode[0]));
         if (cfg_we) begin
            en      <= cfg_data[CFG_EN_BIT];
            mode    <= irq_mode_e'(cfg_data[CFG_MODE_MSB:CFG_MODE_LSB]);
            pending <= 1'b0;
            overrun <= 1'b0;
         end else if (edge_mode) begin
            if (en && edge_hit) begin
               pending <= 1'b1;
               if (pending && !ack) overrun <= 1'b1;
            end else if (ack) begin
               pending <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/n101_subsys_clic_irq_cond.sv
// Interrupt conditioner/allocator: conditions SRC_NUM peripheral sources and
// places them on CLIC lines IRQ_BASE .. IRQ_BASE+SRC_NUM-1.
module n101_subsys_clic_irq_cond
   import n101_subsys_clic_irq_cond_pkg::*;
#(
   parameter int                 SRC_NUM     = 32,
   parameter int                 IRQ_NUM     = `N101_CLIC_IRQ_NUM,
   parameter int                 IRQ_BASE    = 0,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [SRC_NUM-1:0] RST_EN      = {SRC_NUM{1'b1}},
   parameter int                 IDX_W       = `N101_CLOG2(SRC_NUM),
   parameter int                 ID_W        = `N101_CLOG2(IRQ_NUM)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SRC_NUM-1:0] src_irq,
   input  logic               cfg_wr_en,
   input  logic [IDX_W-1:0]   cfg_wr_idx,
   input  logic [CFG_W-1:0]   cfg_wr_data,
   input  logic [IDX_W-1:0]   cfg_rd_idx,
   output logic [RD_W-1:0]    cfg_rd_data,
   input  logic               clic_ack_vld,
   input  logic [ID_W-1:0]    clic_ack_id,
   output logic [IRQ_NUM-1:0] clic_irq_i
);

   if (SRC_NUM < 1 || IRQ_BASE < 0 || IRQ_BASE + SRC_NUM > IRQ_NUM) begin : g_bad_map
      $error("n101_subsys_clic_irq_cond: sources do not fit in the CLIC vector");
   end
   if (SYNC_STAGES < 1) begin : g_bad_sync
      $error("n101_subsys_clic_irq_cond: SYNC_STAGES must be at least 1");
   end

   logic [SRC_NUM-1:0] ch_irq;
   logic [SRC_NUM-1:0] ch_en;
   logic [SRC_NUM-1:0] ch_pend;
   logic [SRC_NUM-1:0] ch_ovr;
   logic [SRC_NUM-1:0] wr_sel;
   logic [SRC_NUM-1:0] ack_sel;
   irq_mode_e          ch_mode [SRC_NUM];

   for (genvar i = 0; i < SRC_NUM; i++) begin : g_ch
      // Out-of-range write indices and ack ids simply match no channel
      assign wr_sel[i]  = cfg_wr_en && (cfg_wr_idx == IDX_W'(i));
      assign ack_sel[i] = clic_ack_vld && (clic_ack_id == ID_W'(IRQ_BASE + i));

      n101_subsys_irq_cond_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .RST_EN      (RST_EN[i])
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .src      (src_irq[i]),
         .cfg_we   (wr_sel[i]),
         .cfg_data (cfg_wr_data),
         .ack      (ack_sel[i]),
         .irq      (ch_irq[i]),
         .en       (ch_en[i]),
         .mode     (ch_mode[i]),
         .pending  (ch_pend[i]),
         .overrun  (ch_ovr[i])
      );
   end

   always_comb begin
      cfg_rd_data = '0;
      for (int i = 0; i < SRC_NUM; i++) begin
         if (cfg_rd_idx == IDX_W'(i)) begin
            cfg_rd_data = {ch_ovr[i], ch_pend[i], ch_en[i], ch_mode[i]};
         end
      end
   end

   always_comb begin
      clic_irq_i = '0;
      clic_irq_i[IRQ_BASE +: SRC_NUM] = ch_irq;
   end

endmodule

// File: tb/tb_n101_subsys_clic_irq_cond.sv
// Directed bench for the CLIC interrupt conditioner: default mapping instance
// plus an offset-mapped instance (8 sources at line 16 of 32).
module tb_n101_subsys_clic_irq_cond;

   logic        clk;
   logic        rst;
   logic [31:0] src_irq;
   logic        cfg_wr_en;
   logic [4:0]  cfg_wr_idx;
   logic [2:0]  cfg_wr_data;
   logic [4:0]  cfg_rd_idx;
   logic [4:0]  cfg_rd_data;
   logic        clic_ack_vld;
   logic [5:0]  clic_ack_id;
   logic [63:0] clic_irq_i;

   logic        rst2;
   logic [7:0]  src2;
   logic [2:0]  rd_idx2;
   logic [4:0]  rd_data2;
   logic [31:0] clic2;

   int total  = 0;
   int passes = 0;

   n101_subsys_clic_irq_cond u_dut (
      .clk          (clk),
      .rst          (rst),
      .src_irq      (src_irq),
      .cfg_wr_en    (cfg_wr_en),
      .cfg_wr_idx   (cfg_wr_idx),
      .cfg_wr_data  (cfg_wr_data),
      .cfg_rd_idx   (cfg_rd_idx),
      .cfg_rd_data  (cfg_rd_data),
      .clic_ack_vld (clic_ack_vld),
      .clic_ack_id  (clic_ack_id),
      .clic_irq_i   (clic_irq_i)
   );

   n101_subsys_clic_irq_cond #(
      .SRC_NUM  (8),
      .IRQ_NUM  (32),
      .IRQ_BASE (16)
   ) u_off (
      .clk          (clk),
      .rst          (rst2),
      .src_irq      (src2),
      .cfg_wr_en    (1'b0),
      .cfg_wr_idx   (3'd0),
      .cfg_wr_data  (3'd0),
      .cfg_rd_idx   (rd_idx2),
      .cfg_rd_data  (rd_data2),
      .clic_ack_vld (1'b0),
      .clic_ack_id  (5'd0),
      .clic_irq_i   (clic2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic rd_check(input string tag, input logic [4:0] idx, input logic [4:0] exp);
      cfg_rd_idx = idx;
      #1;
      check(tag, 64'(cfg_rd_data), 64'(exp));
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr_cfg(input logic [4:0] idx, input logic [2:0] data);
      cfg_wr_en   = 1'b1;
      cfg_wr_idx  = idx;
      cfg_wr_data = data;
      @(negedge clk);
      cfg_wr_en   = 1'b0;
   endtask

   initial begin
      clk          = 1'b0;
      rst          = 1'b1;
      rst2         = 1'b1;
      src_irq      = 32'h4000_0000;
      src2         = 8'h00;
      cfg_wr_en    = 1'b0;
      cfg_wr_idx   = '0;
      cfg_wr_data  = '0;
      cfg_rd_idx   = '0;
      rd_idx2      = '0;
      clic_ack_vld = 1'b0;
      clic_ack_id  = '0;

      // Reset defaults and first-sample latency
      tick(2);
      check("rst_irq", clic_irq_i, 64'h0);
      rd_check("rst_rd30", 5'd30, 5'b00100);
      rst  = 1'b0;
      rst2 = 1'b0;
      tick(2);
      check("lat_pre", clic_irq_i, 64'h0);
      tick(1);
      check("lat_hit", clic_irq_i, 64'h4000_0000);

      // Level-low on source 5
      wr_cfg(5'd5, 3'b101);
      rd_check("lo_cfg", 5'd5, 5'b00101);
      tick(1);
      check("lo_act", 64'(clic_irq_i[5]), 64'h1);
      src_irq[5] = 1'b1;
      tick(2);
      check("lo_hold", 64'(clic_irq_i[5]), 64'h1);
      tick(1);
      check("lo_off", 64'(clic_irq_i[5]), 64'h0);

      // Rising edge, pending, ack
      wr_cfg(5'd7, 3'b110);
      src_irq[7] = 1'b1;
      tick(1);
      src_irq[7] = 1'b0;
      tick(2);
      check("rise_c3", 64'(clic_irq_i[7]), 64'h0);
      rd_check("rise_pend", 5'd7, 5'b01110);
      tick(1);
      check("rise_c4", 64'(clic_irq_i[7]), 64'h1);
      tick(1);
      clic_ack_vld = 1'b1;
      clic_ack_id  = 6'd40;
      tick(1);
      clic_ack_vld = 1'b0;
      tick(1);
      check("ack40_irq", 64'(clic_irq_i[7]), 64'h1);
      rd_check("ack40_rd", 5'd7, 5'b01110);
      clic_ack_vld = 1'b1;
      clic_ack_id  = 6'd7;
      tick(1);
      clic_ack_vld = 1'b0;
      rd_check("ack7_rd", 5'd7, 5'b00110);
      tick(1);
      check("ack7_irq", 64'(clic_irq_i[7]), 64'h0);

      // Falling edge, collision with ack, overrun, clear by write
      wr_cfg(5'd3, 3'b111);
      src_irq[3] = 1'b1;
      tick(4);
      src_irq[3] = 1'b0;
      tick(4);
      rd_check("fall_pend", 5'd3, 5'b01111);
      check("fall_irq", 64'(clic_irq_i[3]), 64'h1);
      src_irq[3] = 1'b1;
      tick(4);
      src_irq[3] = 1'b0;
      tick(2);
      clic_ack_vld = 1'b1;
      clic_ack_id  = 6'd3;
      tick(1);
      clic_ack_vld = 1'b0;
      rd_check("collide", 5'd3, 5'b01111);
      src_irq[3] = 1'b1;
      tick(4);
      src_irq[3] = 1'b0;
      tick(4);
      rd_check("overrun", 5'd3, 5'b11111);
      wr_cfg(5'd3, 3'b111);
      rd_check("wr_clear", 5'd3, 5'b00111);

      // Disable / re-enable on source 9
      src_irq[9] = 1'b1;
      tick(4);
      check("en_on", 64'(clic_irq_i[9]), 64'h1);
      wr_cfg(5'd9, 3'b000);
      tick(1);
      check("dis_off", 64'(clic_irq_i[9]), 64'h0);
      wr_cfg(5'd9, 3'b100);
      tick(1);
      check("reen_lvl", 64'(clic_irq_i[9]), 64'h1);
      wr_cfg(5'd9, 3'b010);
      wr_cfg(5'd9, 3'b110);
      tick(3);
      rd_check("reen_rise", 5'd9, 5'b00110);
      check("reen_irq", 64'(clic_irq_i[9]), 64'h0);
      check("full_vec", clic_irq_i, 64'h4000_0000);

      // Offset mapping and asynchronous reset
      src2[0] = 1'b1;
      tick(2);
      check("off_pre", 64'(clic2), 64'h0);
      tick(1);
      check("off_map", 64'(clic2), 64'h0001_0000);
      rd_idx2 = 3'd0;
      #1;
      check("off_rd", 64'(rd_data2), 64'h04);
      #1;
      rst2 = 1'b1;
      #1;
      check("async_rst", 64'(clic2), 64'h0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
